ysyx_icache: RTL
================

Name: ysyx_icache

Overview:
- Direct-mapped instruction cache between the IFU fetch port and the bus arbiter's IFU port.
- Drop-in on both sides: it presents to the IFU the same araddr/arvalid/rdata/rvalid interface the arbiter exposes, and it drives the arbiter with single-word reads.
- Hits return the instruction one cycle after the request; misses refill a whole line word by word.
- fence_i invalidates the entire cache.

Parameters:
- ADDR_W, 32, address and data width (one instruction word per beat).
- OFFSET_BITS, 4, log2 of line size in bytes (16 B = 4 words).
- INDEX_BITS, 4, log2 of line count (16 lines).
- CACHE_LO, 32'h30000000, inclusive lower bound of the cacheable region.
- CACHE_HI, 32'hA0000000, exclusive upper bound of the cacheable region.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- ifu_araddr, in, ADDR_W, fetch address; word aligned; held stable while ifu_arvalid is high.
- ifu_arvalid, in, 1, fetch request; held high until ifu_rvalid.
- ifu_rdata_o, out, ADDR_W, instruction word.
- ifu_rvalid_o, out, 1, one-cycle pulse; ifu_rdata_o is valid in this cycle.
- bus_araddr_o, out, ADDR_W, refill/bypass word address to the arbiter.
- bus_arvalid_o, out, 1, read request to the arbiter; held until bus_rvalid.
- bus_rdata, in, ADDR_W, read data from the arbiter.
- bus_rvalid, in, 1, one-cycle read-data valid from the arbiter.
- fence_i, in, 1, invalidate-all pulse.
- hit_cnt_o, out, 32, saturating hit counter.
- miss_cnt_o, out, 32, saturating miss counter (bypass fetches included).

Behaviour:
- Address split: offset = addr[OFFSET_BITS-1:0]; word select = addr[OFFSET_BITS-1:2]; index = next INDEX_BITS; tag = remaining upper bits.
- Storage: valid bit and tag per line; data array of lines x words. Valid bits are flops cleared by rst; data/tag arrays need no reset.
- Cacheable request: CACHE_LO <= addr < CACHE_HI. Anything else is a bypass request.
- Reset (async, any state): state=IDLE; all valid=0; ifu_rvalid_o=0; ifu_rdata_o=0; bus_arvalid_o=0; bus_araddr_o=0; counters=0; an in-flight refill is abandoned with no line marked valid.
- FSM states: IDLE, LOOKUP, REFILL, BYPASS, RESP.
- IDLE:
  - ifu_arvalid=1 -> register the address, go to LOOKUP.
  - While in IDLE, ifu_rvalid_o=0.
- LOOKUP:
  - Hit (cacheable, valid, tag equal) -> ifu_rdata_o = data word, ifu_rvalid_o=1 this cycle, hit_cnt++, go to IDLE.
  - Hit latency: request seen in IDLE at cycle N, rvalid at cycle N+1.
  - Cacheable miss -> miss_cnt++, word counter k=0, go to REFILL.
  - Non-cacheable -> miss_cnt++, go to BYPASS.
- REFILL:
  - bus_araddr_o = {line base, k, 2'b00}; bus_arvalid_o=1.
  - On bus_rvalid: write bus_rdata to data[index][k]; drop bus_arvalid_o for one cycle; k++.
  - After the last word (k = 2^(OFFSET_BITS-2)-1 accepted): write the tag; set valid unless a fence_i arrived during the refill; go to RESP.
  - Words are always fetched in order 0..last, never critical-word-first.
- BYPASS:
  - bus_araddr_o = registered address; bus_arvalid_o=1.
  - On bus_rvalid: capture the data, go to RESP. No array update.
- RESP:
  - ifu_rvalid_o=1 for exactly one cycle.
  - ifu_rdata_o = requested word (refilled line) or captured bypass data.
  - Next state IDLE.
- ifu_rdata_o holds its last value between pulses.
- fence_i:
  - In IDLE/LOOKUP: all valid bits cleared next edge. If it coincides with a LOOKUP hit, the hit is still served (the data is architecturally stale-safe for that fetch), then invalidation takes effect.
  - In REFILL: set a pending-kill flag; the refill finishes and the requested word is delivered, but the line stays invalid. The flag clears on entry to IDLE.
- Counters saturate at 32'hFFFFFFFF and never wrap.
- One request is outstanding at a time; a new ifu_arvalid is only sampled in IDLE.
- bus_arvalid_o is never asserted in IDLE, LOOKUP, or RESP.

Test Plan:
- Cold miss: reset, fetch 0x30000004 -> four bus reads at 0x30000000/4/8/C in order; ifu_rdata_o = mem[0x30000004] one cycle after the last bus_rvalid; miss_cnt=1.
- Hit after fill: fetch 0x3000000C following the cold miss -> no bus activity; ifu_rvalid_o exactly 1 cycle after the request; hit_cnt=1.
- Conflict eviction: fetch 0x30000100 (same index, different tag with default params) -> full refill; then 0x30000000 misses again; miss_cnt=3.
- Bypass: fetch 0x0F000000 twice -> two single-word bus reads, no line filled; miss_cnt +2; hit_cnt unchanged.
- fence_i mid-refill: pulse during the 2nd refill beat of 0x30000020 -> word delivered correctly; a following fetch of 0x30000020 misses again.
- Async reset mid-refill: assert rst between bus beats -> bus_arvalid_o=0 immediately; after release, the earlier filled line 0x30000000 misses.

Source files
------------

// File: rtl/ysyx_icache.sv
// ysyx_icache: direct-mapped instruction cache between the IFU and the bus arbiter.
// Hits answer in the cycle after the request; misses refill a full line in word order.
module ysyx_icache #(
    parameter int              ADDR_W      = 32,
    parameter int              OFFSET_BITS = 4,
    parameter int              INDEX_BITS  = 4,
    parameter logic [ADDR_W-1:0] CACHE_LO  = 32'h30000000,
    parameter logic [ADDR_W-1:0] CACHE_HI  = 32'hA0000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    output logic [ADDR_W-1:0] ifu_rdata_o,
    output logic              ifu_rvalid_o,
    output logic [ADDR_W-1:0] bus_araddr_o,
    output logic              bus_arvalid_o,
    input  logic [ADDR_W-1:0] bus_rdata,
    input  logic              bus_rvalid,
    input  logic              fence_i,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);
    localparam int WSEL_W = OFFSET_BITS - 2;
    localparam int LINES  = 1 << INDEX_BITS;
    localparam int WORDS  = 1 << WSEL_W;
    localparam int TAG_W  = ADDR_W - OFFSET_BITS - INDEX_BITS;

    typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, BYPASS, RESP} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WSEL_W-1:0]   k_q, k_d;
    logic                kill_q, kill_d;
    logic                drop_q, drop_d;
    logic [ADDR_W-1:0]   buf_q, buf_d;
    logic [ADDR_W-1:0]   rdata_q;
    logic [31:0]         hit_q, hit_d, miss_q, miss_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic                data_we, tag_we;

    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [ADDR_W-1:0]   data_q [LINES][WORDS];

    logic [INDEX_BITS-1:0] idx;
    logic [WSEL_W-1:0]     wsel;
    logic [TAG_W-1:0]      tag;
    logic                  cacheable, hit;

    assign idx       = addr_q[OFFSET_BITS +: INDEX_BITS];
    assign wsel      = addr_q[2 +: WSEL_W];
    assign tag       = addr_q[ADDR_W-1 -: TAG_W];
    assign cacheable = (addr_q >= CACHE_LO) && (addr_q < CACHE_HI);
    assign hit       = cacheable && valid_q[idx] && (tag_q[idx] == tag);
    assign hit_cnt_o  = hit_q;
    assign miss_cnt_o = miss_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        k_d           = k_q;
        kill_d        = kill_q;
        drop_d        = 1'b0;
        buf_d         = buf_q;
        valid_d       = valid_q;
        hit_d         = hit_q;
        miss_d        = miss_q;
        data_we       = 1'b0;
        tag_we        = 1'b0;
        ifu_rvalid_o  = 1'b0;
        ifu_rdata_o   = rdata_q;
        bus_arvalid_o = 1'b0;
        bus_araddr_o  = '0;
        // Outside a refill an invalidate takes effect at the next edge.
        if (fence_i && state_q != REFILL) valid_d = '0;
        unique case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (ifu_arvalid) begin
                    addr_d  = ifu_araddr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    ifu_rvalid_o = 1'b1;
                    ifu_rdata_o  = data_q[idx][wsel];
                    hit_d        = (hit_q == '1) ? hit_q : hit_q + 32'd1;
                    state_d      = IDLE;
                end else begin
                    miss_d  = (miss_q == '1) ? miss_q : miss_q + 32'd1;
                    k_d     = '0;
                    state_d = cacheable ? REFILL : BYPASS;
                end
            end
            REFILL: begin
                bus_araddr_o  = {addr_q[ADDR_W-1:OFFSET_BITS], k_q, 2'b00};
                bus_arvalid_o = !drop_q;
                if (fence_i) kill_d = 1'b1;
                if (bus_rvalid && !drop_q) begin
                    data_we = 1'b1;
                    drop_d  = 1'b1;
                    k_d     = k_q + 1'b1;
                    if (k_q == WSEL_W'(WORDS - 1)) begin
                        tag_we       = 1'b1;
                        valid_d[idx] = !(kill_q || fence_i);
                        state_d      = RESP;
                    end
                end
            end
            BYPASS: begin
                bus_araddr_o  = addr_q;
                bus_arvalid_o = 1'b1;
                if (bus_rvalid) begin
                    buf_d   = bus_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                ifu_rvalid_o = 1'b1;
                ifu_rdata_o  = cacheable ? data_q[idx][wsel] : buf_q;
                kill_d       = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            k_q     <= '0;
            kill_q  <= 1'b0;
            drop_q  <= 1'b0;
            buf_q   <= '0;
            rdata_q <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            k_q     <= k_d;
            kill_q  <= kill_d;
            drop_q  <= drop_d;
            buf_q   <= buf_d;
            rdata_q <= ifu_rdata_o;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) data_q[idx][k_q] <= bus_rdata;
        if (tag_we)  tag_q[idx] <= tag;
    end
endmodule
